// File: rtl/counter_pkg.sv
// Shared types and constants for the up-counting interval timer.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cnt_state_t;

  localparam logic [3:0] WRAP_MAX = 4'd15;

endpackage : counter_pkg

// File: rtl/counter_up_timer_if.sv
// Control/status bundle between the timer and its controller.
// With COUNTER_UP_WRAPCNT_EN defined the bundle also carries the 4-bit reload count.
interface counter_up_timer_if #(parameter int dw = 8);

  logic          start;
  logic          stop;
  logic          ena;
  logic [dw-1:0] limit;
  logic [dw-1:0] result;
  logic          busy;
  logic          done;
  logic          tc;
`ifdef COUNTER_UP_WRAPCNT_EN
  logic [3:0]    wraps;

  modport master (output start, stop, ena, limit,
                  input  result, busy, done, tc, wraps);
  modport slave  (input  start, stop, ena, limit,
                  output result, busy, done, tc, wraps);
`else
  modport master (output start, stop, ena, limit,
                  input  result, busy, done, tc);
  modport slave  (input  start, stop, ena, limit,
                  output result, busy, done, tc);
`endif

endinterface : counter_up_timer_if

// File: rtl/counter_up_core.sv
// Count register with clear/increment/hold and an equality flag against the latched limit.
module counter_up_core #(
  parameter int dw = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic [dw-1:0] limit_q_i,
  output logic [dw-1:0] count_o,
  output logic          eq_o
);

  logic [dw-1:0] count_q;
  logic [dw-1:0] count_d;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + {{(dw-1){1'b0}}, 1'b1};
    end
  end

  // NOTE: state is updated with non-blocking assignments so all registers sample together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign eq_o    = (count_q == limit_q_i);

endmodule : counter_up_core

// File: rtl/counter_up_timer.sv
// Up-counting interval timer: one-shot (AUTO_RELOAD=0) or auto-reload (AUTO_RELOAD=1).
// Optional macro COUNTER_UP_WRAPCNT_EN adds a saturating count of terminal-count pulses.
module counter_up_timer
  import counter_pkg::*;
#(
  parameter int dw          = 8,
  parameter int AUTO_RELOAD = 0
) (
  input  logic               clk,
  input  logic               reset,
  counter_up_timer_if.slave  bus
);

  cnt_state_t    state_q, state_d;
  logic [dw-1:0] limit_q, limit_d;
  logic          tc_q, tc_d;
  logic          clr, inc, eq;
  logic          start_acc;
  logic [dw-1:0] count;

  // stop outranks start everywhere; start is accepted in every state.
  assign start_acc = bus.start && !bus.stop;

  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    tc_d    = 1'b0;
    clr     = 1'b0;
    inc     = 1'b0;
    if (bus.stop) begin
      state_d = IDLE;
    end else if (start_acc) begin
      limit_d = bus.limit;
      clr     = 1'b1;
      state_d = RUN;
    end else if (state_q == RUN && bus.ena) begin
      if (eq) begin
        tc_d = 1'b1;
        if (AUTO_RELOAD != 0) clr = 1'b1;
        else                  state_d = DONE;
      end else begin
        inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      limit_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      tc_q    <= tc_d;
    end
  end

  counter_up_core #(.dw(dw)) u_core (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (clr),
    .inc_i     (inc),
    .limit_q_i (limit_q),
    .count_o   (count),
    .eq_o      (eq)
  );

  assign bus.result = count;
  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.tc     = tc_q;

`ifdef COUNTER_UP_WRAPCNT_EN
  logic [3:0] wraps_q, wraps_d;

  always_comb begin
    wraps_d = wraps_q;
    if (start_acc) begin
      wraps_d = 4'd0;
    end else if (tc_d && wraps_q != WRAP_MAX) begin
      wraps_d = wraps_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wraps_q <= 4'd0;
    else       wraps_q <= wraps_d;
  end

  assign bus.wraps = wraps_q;
`endif

endmodule : counter_up_timer

// File: tb/tb_counter_up_timer.sv
// Self-checking bench: one one-shot and one auto-reload timer, vector tables plus corner sequences.
module tb_counter_up_timer;

  typedef struct {
    bit       dut;     // 0: one-shot instance, 1: auto-reload instance
    bit       start;
    bit       stop;
    bit       ena;
    bit [7:0] limit;
    bit [7:0] result;
    bit       busy;
    bit       done;
    bit       tc;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   vec_idx  = 0;
  vec_t sb_q[$];
  vec_t os_tbl[$];
  vec_t ar_tbl[$];

  always #5 clk = ~clk;

  counter_up_timer_if #(.dw(8)) os_if ();
  counter_up_timer_if #(.dw(8)) ar_if ();

  counter_up_timer #(.dw(8), .AUTO_RELOAD(0)) dut_os (.clk(clk), .reset(reset), .bus(os_if.slave));
  counter_up_timer #(.dw(8), .AUTO_RELOAD(1)) dut_ar (.clk(clk), .reset(reset), .bus(ar_if.slave));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit d, bit st, bit sp, bit en, bit [7:0] lim,
                              bit [7:0] res, bit bz, bit dn, bit t);
    vec_t v;
    v.dut = d; v.start = st; v.stop = sp; v.ena = en; v.limit = lim;
    v.result = res; v.busy = bz; v.done = dn; v.tc = t;
    return v;
  endfunction

  task automatic idle_inputs();
    os_if.start = 1'b0; os_if.stop = 1'b0; os_if.ena = 1'b0; os_if.limit = 8'd0;
    ar_if.start = 1'b0; ar_if.stop = 1'b0; ar_if.ena = 1'b0; ar_if.limit = 8'd0;
  endtask

  // Drive one vector on a negedge, push its expectation, compare after the next posedge.
  task automatic cycle(input vec_t v);
    vec_t e;
    @(negedge clk);
    idle_inputs();
    if (v.dut) begin
      ar_if.start = v.start; ar_if.stop = v.stop; ar_if.ena = v.ena; ar_if.limit = v.limit;
    end else begin
      os_if.start = v.start; os_if.stop = v.stop; os_if.ena = v.ena; os_if.limit = v.limit;
    end
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    vec_idx++;
    if (sb_q.size() == 0) begin
      check($sformatf("v%0d.scoreboard_empty", vec_idx), 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      if (e.dut) begin
        check($sformatf("v%0d.ar.result", vec_idx), ar_if.result, e.result);
        check($sformatf("v%0d.ar.busy",   vec_idx), ar_if.busy,   e.busy);
        check($sformatf("v%0d.ar.done",   vec_idx), ar_if.done,   e.done);
        check($sformatf("v%0d.ar.tc",     vec_idx), ar_if.tc,     e.tc);
      end else begin
        check($sformatf("v%0d.os.result", vec_idx), os_if.result, e.result);
        check($sformatf("v%0d.os.busy",   vec_idx), os_if.busy,   e.busy);
        check($sformatf("v%0d.os.done",   vec_idx), os_if.done,   e.done);
        check($sformatf("v%0d.os.tc",     vec_idx), os_if.tc,     e.tc);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // One-shot: limit=3 run, re-arm with limit=0, ena gaps, restart, stop+start.
    os_tbl.push_back(mk(0,1,0,0,3, 0,1,0,0));
    os_tbl.push_back(mk(0,0,0,1,0, 1,1,0,0));
    os_tbl.push_back(mk(0,0,0,1,0, 2,1,0,0));
    os_tbl.push_back(mk(0,0,0,1,0, 3,1,0,0));
    os_tbl.push_back(mk(0,0,0,1,0, 3,0,1,1));
    os_tbl.push_back(mk(0,0,0,1,0, 3,0,1,0));
    os_tbl.push_back(mk(0,0,0,0,0, 3,0,1,0));
    os_tbl.push_back(mk(0,1,0,0,0, 0,1,0,0));
    os_tbl.push_back(mk(0,0,0,1,0, 0,0,1,1));
    os_tbl.push_back(mk(0,0,0,1,0, 0,0,1,0));
    os_tbl.push_back(mk(0,1,0,0,9, 0,1,0,0));
    os_tbl.push_back(mk(0,0,0,1,0, 1,1,0,0));
    os_tbl.push_back(mk(0,0,0,1,0, 2,1,0,0));
    os_tbl.push_back(mk(0,0,0,1,0, 3,1,0,0));
    os_tbl.push_back(mk(0,0,0,1,0, 4,1,0,0));
    os_tbl.push_back(mk(0,0,0,1,0, 5,1,0,0));
    os_tbl.push_back(mk(0,0,0,0,0, 5,1,0,0));
    os_tbl.push_back(mk(0,0,0,0,0, 5,1,0,0));
    os_tbl.push_back(mk(0,0,0,1,0, 6,1,0,0));
    os_tbl.push_back(mk(0,1,0,1,1, 0,1,0,0));
    os_tbl.push_back(mk(0,0,0,1,7, 1,1,0,0));
    os_tbl.push_back(mk(0,0,0,1,7, 1,0,1,1));
    os_tbl.push_back(mk(0,1,0,0,5, 0,1,0,0));
    os_tbl.push_back(mk(0,0,0,1,0, 1,1,0,0));
    os_tbl.push_back(mk(0,0,0,1,0, 2,1,0,0));
    os_tbl.push_back(mk(0,1,1,1,9, 2,0,0,0));
    os_tbl.push_back(mk(0,0,0,1,9, 2,0,0,0));

    // Auto-reload: limit=2 with ena high for nine cycles, then ena low.
    ar_tbl.push_back(mk(1,1,0,0,2, 0,1,0,0));
    for (int i = 1; i <= 9; i++) begin
      ar_tbl.push_back(mk(1,0,0,1,0, 8'(i % 3), 1, 0, (i % 3) == 0));
    end
    ar_tbl.push_back(mk(1,0,0,0,0, 0,1,0,0));

    idle_inputs();
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("reset.os.result", os_if.result, 0);
    check("reset.os.busy",   os_if.busy,   0);
    check("reset.os.done",   os_if.done,   0);
    check("reset.os.tc",     os_if.tc,     0);
    check("reset.ar.result", ar_if.result, 0);
    check("reset.ar.busy",   ar_if.busy,   0);
`ifdef COUNTER_UP_WRAPCNT_EN
    check("reset.os.wraps",  os_if.wraps,  0);
    check("reset.ar.wraps",  ar_if.wraps,  0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // Asynchronous reset mid-count: one-shot at result=5, auto-reload on a tc cycle.
    @(negedge clk);
    os_if.start = 1'b1; os_if.limit = 8'd9;
    ar_if.start = 1'b1; ar_if.limit = 8'd4;
    @(negedge clk);
    os_if.start = 1'b0; os_if.ena = 1'b1;
    ar_if.start = 1'b0; ar_if.ena = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("midcount.os.result", os_if.result, 5);
    check("midcount.os.busy",   os_if.busy,   1);
    check("midcount.ar.tc",     ar_if.tc,     1);
    #2 reset = 1'b1;
    #1;
    check("async_reset.os.result", os_if.result, 0);
    check("async_reset.os.busy",   os_if.busy,   0);
    check("async_reset.os.done",   os_if.done,   0);
    check("async_reset.os.tc",     os_if.tc,     0);
    check("async_reset.ar.tc",     ar_if.tc,     0);
    check("async_reset.ar.busy",   ar_if.busy,   0);
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;

    foreach (os_tbl[i]) cycle(os_tbl[i]);
    check("stop_start.limit_q_held", dut_os.limit_q, 5);
    cycle(mk(0,1,0,0,0, 0,1,0,0));
    cycle(mk(0,0,1,1,0, 0,0,0,0));

    // Full-range limit: no overflow past 255, terminal count then DONE, then stop from DONE.
    cycle(mk(0,1,0,0,255, 0,1,0,0));
    for (int i = 1; i <= 255; i++) cycle(mk(0,0,0,1,0, 8'(i),1,0,0));
    cycle(mk(0,0,0,1,0, 255,0,1,1));
    cycle(mk(0,0,0,1,0, 255,0,1,0));
    cycle(mk(0,0,1,0,0, 255,0,0,0));

    foreach (ar_tbl[i]) cycle(ar_tbl[i]);
`ifdef COUNTER_UP_WRAPCNT_EN
    check("wraps.after_three", ar_if.wraps, 3);
`endif

    // limit=0 in auto-reload: tc every enabled cycle; wrap count saturates.
    cycle(mk(1,1,0,0,0, 0,1,0,0));
`ifdef COUNTER_UP_WRAPCNT_EN
    check("wraps.cleared_on_start", ar_if.wraps, 0);
`endif
    for (int i = 0; i < 20; i++) cycle(mk(1,0,0,1,0, 0,1,0,1));
`ifdef COUNTER_UP_WRAPCNT_EN
    check("wraps.saturated", ar_if.wraps, 15);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_counter_up_timer
